// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: accepts decode-stage exceptions, ecall/ebreak, mret and
// the external interrupt, drains the pipeline, writes the trap CSRs and redirects fetch.
module trap_controller #(
  parameter int DRAIN_TIMEOUT = 16,
  parameter bit VECTORED_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] instr_pc_i,
  input  logic        illegal_instr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        mstatus_mie_i,
  input  logic        mie_meie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        pipeline_idle_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o,
  output logic        csr_trap_we_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mtval_o,
  output logic        mstatus_trap_o,
  output logic        mstatus_mret_o,
  output logic        busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_SAVE  = 3'd2;
  localparam logic [2:0] S_JUMP  = 3'd3;
  localparam logic [2:0] S_RET   = 3'd4;

  localparam int              CW       = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [31:0]     CAUSE_IRQ    = 32'h8000_000B;
  localparam logic [31:0]     CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0]     CAUSE_EBREAK = 32'd3;
  localparam logic [31:0]     CAUSE_ECALL  = 32'd11;

  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [31:0]   cause_r;
  logic [31:0]   tval_r;
  logic [31:0]   epc_r;
  logic          irq_r;
  logic [31:0]   target_hold_r;

  logic          irq_s;
  logic          trap_s;
  logic          ret_s;
  logic          is_irq_s;
  logic [31:0]   cause_s;
  logic [31:0]   tval_s;
  logic          drain_done_s;
  logic [31:0]   base_s;
  logic [31:0]   jump_target_s;

  // Event priority decode; only a valid decode-stage slot can take a trap.
  always_comb begin
    irq_s    = irq_ext_i & mstatus_mie_i & mie_meie_i;
    trap_s   = 1'b0;
    ret_s    = 1'b0;
    is_irq_s = 1'b0;
    cause_s  = 32'd0;
    tval_s   = 32'd0;
    if (instr_valid_i) begin
      if (irq_s) begin
        trap_s   = 1'b1;
        is_irq_s = 1'b1;
        cause_s  = CAUSE_IRQ;
      end else if (illegal_instr_i) begin
        trap_s  = 1'b1;
        cause_s = CAUSE_ILLEGAL;
        tval_s  = instr_i;
      end else if (ebreak_i) begin
        trap_s  = 1'b1;
        cause_s = CAUSE_EBREAK;
      end else if (ecall_i) begin
        trap_s  = 1'b1;
        cause_s = CAUSE_ECALL;
      end else if (mret_i) begin
        ret_s = 1'b1;
      end else begin
        ret_s = 1'b0;
      end
    end else begin
      trap_s = 1'b0;
    end
  end

  assign drain_done_s = pipeline_idle_i || (cnt_r == CNT_LAST);

  // Sequencer next-state; events outside IDLE are deliberately dropped.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (trap_s) begin
          state_nxt_s = S_FLUSH;
        end else if (ret_s) begin
          state_nxt_s = S_RET;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (drain_done_s) begin
          state_nxt_s = S_SAVE;
        end else begin
          state_nxt_s = S_FLUSH;
        end
      end
      S_SAVE:  state_nxt_s = S_JUMP;
      S_JUMP:  state_nxt_s = S_IDLE;
      S_RET:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Vectored mode only applies to interrupts; mtvec is read live in JUMP.
  always_comb begin
    base_s = {mtvec_i[31:2], 2'b00};
    if (VECTORED_EN && (mtvec_i[1:0] == 2'b01) && irq_r) begin
      jump_target_s = base_s + {25'd0, cause_r[4:0], 2'b00};
    end else begin
      jump_target_s = base_s;
    end
  end

  // PC target is live during a redirect and otherwise holds the last redirect value.
  always_comb begin
    case (state_r)
      S_JUMP:  pc_target_o = jump_target_s;
      S_RET:   pc_target_o = {mepc_i[31:1], 1'b0};
      default: pc_target_o = target_hold_r;
    endcase
  end

  assign stall_o        = (state_r != S_IDLE);
  assign busy_o         = (state_r != S_IDLE);
  assign flush_o        = (state_r == S_FLUSH) || (state_r == S_RET);
  assign pc_redirect_o  = (state_r == S_JUMP) || (state_r == S_RET);
  assign csr_trap_we_o  = (state_r == S_SAVE);
  assign mstatus_trap_o = (state_r == S_SAVE);
  assign mstatus_mret_o = (state_r == S_RET);

  // State, drain counter, trap latches and held CSR/PC output values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      cnt_r         <= '0;
      cause_r       <= 32'd0;
      tval_r        <= 32'd0;
      epc_r         <= 32'd0;
      irq_r         <= 1'b0;
      target_hold_r <= 32'd0;
      mepc_o        <= 32'd0;
      mcause_o      <= 32'd0;
      mtval_o       <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == S_FLUSH) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
      if ((state_r == S_IDLE) && trap_s) begin
        cause_r <= cause_s;
        tval_r  <= tval_s;
        epc_r   <= instr_pc_i;
        irq_r   <= is_irq_s;
      end
      if ((state_r == S_FLUSH) && drain_done_s) begin
        mepc_o   <= epc_r;
        mcause_o <= cause_r;
        mtval_o  <= tval_r;
      end
      if (pc_redirect_o) begin
        target_hold_r <= pc_target_o;
      end
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: hand-computed expectations checked with
// immediate assertions at each step.
module tb_trap_controller;

  logic        clk;
  logic        rst_n;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic [31:0] instr_pc_i;
  logic        illegal_instr_i;
  logic        ecall_i;
  logic        ebreak_i;
  logic        mret_i;
  logic        irq_ext_i;
  logic        mstatus_mie_i;
  logic        mie_meie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        pipeline_idle_i;
  logic        stall_o;
  logic        flush_o;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic        csr_trap_we_o;
  logic [31:0] mepc_o;
  logic [31:0] mcause_o;
  logic [31:0] mtval_o;
  logic        mstatus_trap_o;
  logic        mstatus_mret_o;
  logic        busy_o;

  int tests;
  int fails;

  trap_controller #(.DRAIN_TIMEOUT(16), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_pc_i(instr_pc_i),
    .illegal_instr_i(illegal_instr_i), .ecall_i(ecall_i), .ebreak_i(ebreak_i),
    .mret_i(mret_i), .irq_ext_i(irq_ext_i), .mstatus_mie_i(mstatus_mie_i),
    .mie_meie_i(mie_meie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .pipeline_idle_i(pipeline_idle_i),
    .stall_o(stall_o), .flush_o(flush_o), .pc_redirect_o(pc_redirect_o),
    .pc_target_o(pc_target_o), .csr_trap_we_o(csr_trap_we_o),
    .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
    .mstatus_trap_o(mstatus_trap_o), .mstatus_mret_o(mstatus_mret_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_events();
    instr_valid_i   = 1'b0;
    illegal_instr_i = 1'b0;
    ecall_i         = 1'b0;
    ebreak_i        = 1'b0;
    mret_i          = 1'b0;
    irq_ext_i       = 1'b0;
  endtask

  initial begin
    int cycles;
    int saves;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    clear_events();
    instr_i         = 32'd0;
    instr_pc_i      = 32'd0;
    mstatus_mie_i   = 1'b0;
    mie_meie_i      = 1'b0;
    mtvec_i         = 32'd0;
    mepc_i          = 32'd0;
    pipeline_idle_i = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_redirect", {31'd0, pc_redirect_o}, 32'd0);
    chk("rst_target", pc_target_o, 32'd0);
    chk("rst_mcause", mcause_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal instruction, pipeline already idle
    instr_valid_i = 1'b1; illegal_instr_i = 1'b1;
    instr_i = 32'hFFFF_FFFF; instr_pc_i = 32'h100; mtvec_i = 32'h200;
    @(negedge clk);
    clear_events();
    chk("ill_flush", {31'd0, flush_o}, 32'd1);
    chk("ill_flush_noredir", {31'd0, pc_redirect_o}, 32'd0);
    @(negedge clk);
    chk("ill_save_we", {31'd0, csr_trap_we_o}, 32'd1);
    chk("ill_save_mtrap", {31'd0, mstatus_trap_o}, 32'd1);
    chk("ill_mcause", mcause_o, 32'd2);
    chk("ill_mepc", mepc_o, 32'h100);
    chk("ill_mtval", mtval_o, 32'hFFFF_FFFF);
    chk("ill_save_noredir", {31'd0, pc_redirect_o}, 32'd0);
    @(negedge clk);
    chk("ill_redirect", {31'd0, pc_redirect_o}, 32'd1);
    chk("ill_target", pc_target_o, 32'h200);
    chk("ill_jump_we", {31'd0, csr_trap_we_o}, 32'd0);
    @(negedge clk);
    chk("ill_idle", {31'd0, busy_o}, 32'd0);
    chk("ill_hold_target", pc_target_o, 32'h200);

    // Priority: irq beats illegal and ecall, vectored mtvec
    instr_valid_i = 1'b1; irq_ext_i = 1'b1; illegal_instr_i = 1'b1; ecall_i = 1'b1;
    mstatus_mie_i = 1'b1; mie_meie_i = 1'b1;
    instr_i = 32'h1234_5678; instr_pc_i = 32'h40; mtvec_i = 32'h201;
    @(negedge clk);
    clear_events();
    chk("pri_flush", {31'd0, flush_o}, 32'd1);
    @(negedge clk);
    chk("pri_mcause", mcause_o, 32'h8000_000B);
    chk("pri_mtval", mtval_o, 32'd0);
    chk("pri_mepc", mepc_o, 32'h40);
    @(negedge clk);
    chk("pri_redirect", {31'd0, pc_redirect_o}, 32'd1);
    chk("pri_target", pc_target_o, 32'h22C);
    @(negedge clk);
    chk("pri_idle", {31'd0, busy_o}, 32'd0);

    // Drain timeout with illegal pulses arriving mid-sequence
    instr_valid_i = 1'b1; ecall_i = 1'b1; instr_pc_i = 32'h80;
    mtvec_i = 32'h300; pipeline_idle_i = 1'b0;
    @(negedge clk);
    clear_events();
    cycles = 0;
    saves = 0;
    while (flush_o === 1'b1 && cycles < 40) begin
      cycles++;
      instr_valid_i = 1'b1; illegal_instr_i = 1'b1; instr_i = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    chk("to_flush_cycles", cycles, 32'd16);
    chk("to_save_we", {31'd0, csr_trap_we_o}, 32'd1);
    chk("to_mcause", mcause_o, 32'd11);
    chk("to_mtval", mtval_o, 32'd0);
    if (csr_trap_we_o === 1'b1) saves++;
    @(negedge clk);
    clear_events();
    if (csr_trap_we_o === 1'b1) saves++;
    chk("to_redirect", {31'd0, pc_redirect_o}, 32'd1);
    chk("to_target", pc_target_o, 32'h300);
    @(negedge clk);
    if (csr_trap_we_o === 1'b1) saves++;
    chk("to_idle", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    if (csr_trap_we_o === 1'b1) saves++;
    chk("to_single_save", saves, 32'd1);
    chk("to_no_retrap", {31'd0, busy_o}, 32'd0);
    pipeline_idle_i = 1'b1;

    // mret
    instr_valid_i = 1'b1; mret_i = 1'b1; mepc_i = 32'h105;
    @(negedge clk);
    clear_events();
    chk("mret_redirect", {31'd0, pc_redirect_o}, 32'd1);
    chk("mret_target", pc_target_o, 32'h104);
    chk("mret_pulse", {31'd0, mstatus_mret_o}, 32'd1);
    chk("mret_no_we", {31'd0, csr_trap_we_o}, 32'd0);
    chk("mret_flush", {31'd0, flush_o}, 32'd1);
    @(negedge clk);
    chk("mret_done", {31'd0, pc_redirect_o}, 32'd0);
    chk("mret_pulse_end", {31'd0, mstatus_mret_o}, 32'd0);
    chk("mret_hold_target", pc_target_o, 32'h104);

    // Masked interrupt, and enabled interrupt without a valid slot
    instr_valid_i = 1'b1; irq_ext_i = 1'b1; mstatus_mie_i = 1'b0;
    @(negedge clk);
    chk("irq_masked", {31'd0, busy_o}, 32'd0);
    instr_valid_i = 1'b0; mstatus_mie_i = 1'b1;
    @(negedge clk);
    chk("irq_novalid", {31'd0, busy_o}, 32'd0);
    clear_events();

    // Reset asserted while in SAVE
    instr_valid_i = 1'b1; ecall_i = 1'b1; instr_pc_i = 32'h500; mtvec_i = 32'h600;
    @(negedge clk);
    clear_events();
    @(negedge clk);
    chk("rs_in_save", {31'd0, csr_trap_we_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_we", {31'd0, csr_trap_we_o}, 32'd0);
    chk("rs_stall", {31'd0, stall_o}, 32'd0);
    chk("rs_mepc", mepc_o, 32'd0);
    chk("rs_mcause", mcause_o, 32'd0);
    chk("rs_target", pc_target_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pc_redirect_o !== 1'b0 || busy_o !== 1'b0) cycles++;
    end
    chk("rs_no_redirect", cycles, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
